ibex_instr_realigner: RTL and testbench

- Sits between the prefetch buffer and the compressed decoder.
- Takes word-aligned 32-bit fetch words and produces one raw instruction per handshake: a 16-bit compressed or a 32-bit full instruction, with its PC.
- Handles the 16-bit stash needed for 32-bit instructions that straddle a word boundary, and handles branches to halfword-aligned targets.
- Output feeds the compressed decoder's valid_i/instr_i; the decoder stays purely combinational.

---
 rtl/ibex_pkg.sv | 7 +
 rtl/ibex_instr_realigner.sv | 163 ++++++++++++++++
 tb/tb_ibex_instr_realigner.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared constants for the Ibex fetch/decode front end.
package ibex_pkg;

    // A halfword whose two low bits are 2'b11 starts a 32-bit instruction.
    localparam logic [1:0] INSTR_OPC_UNCOMP = 2'b11;

endpackage

// File: rtl/ibex_instr_realigner.sv
// Turns word-aligned fetch words into one raw 16- or 32-bit instruction per handshake,
// stashing the upper halfword when an instruction straddles a word boundary.
module ibex_instr_realigner
    import ibex_pkg::*;
#(
    parameter bit ResetAll = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_addr_i,
    input  logic        fetch_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_addr_o,
    output logic        out_is_compressed_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);

    typedef enum logic [1:0] {SEL_S1, SEL_S2, SEL_S3, SEL_S4} sel_e;

    logic        r_stash_v;
    logic        r_skip_low;
    logic        r_stash_err;
    logic [15:0] r_stash;
    logic [31:0] r_stash_addr;

    sel_e        w_sel;
    logic [31:0] w_addr_p2;
    logic        w_lo_uncomp;
    logic        w_hi_uncomp;
    logic        w_stash_uncomp;
    logic        w_valid;
    logic        w_consume;
    logic        w_fr_force;
    logic        w_stash_load;
    logic        w_stash_we;
    logic        w_accept;
    logic        w_active;
    logic [31:0] w_instr;
    logic [31:0] w_addr;
    logic        w_err;
    logic        w_err_plus2;
    logic        w_unused;

    assign w_unused       = ^{branch_addr_i[31:2], branch_addr_i[0]};
    assign w_addr_p2      = fetch_addr_i + 32'd2;
    assign w_lo_uncomp    = (fetch_rdata_i[1:0] == INSTR_OPC_UNCOMP);
    assign w_hi_uncomp    = (fetch_rdata_i[17:16] == INSTR_OPC_UNCOMP);
    assign w_stash_uncomp = (r_stash[1:0] == INSTR_OPC_UNCOMP);

    always_comb begin
        if (r_stash_v) w_sel = w_stash_uncomp ? SEL_S4 : SEL_S3;
        else           w_sel = r_skip_low     ? SEL_S1 : SEL_S2;
    end

    always_comb begin
        w_valid      = 1'b0;
        w_consume    = 1'b0;
        w_fr_force   = 1'b0;
        w_stash_load = 1'b0;
        w_instr      = fetch_rdata_i;
        w_addr       = fetch_addr_i;
        w_err        = fetch_err_i;
        w_err_plus2  = 1'b0;
        case (w_sel)
            SEL_S1: begin
                w_instr = {16'b0, fetch_rdata_i[31:16]};
                w_addr  = w_addr_p2;
                if (!w_hi_uncomp) begin
                    w_valid   = fetch_valid_i;
                    w_consume = 1'b1;
                end else begin
                    // Upper half starts a 32-bit instruction: swallow the word without a handshake.
                    w_fr_force   = fetch_valid_i;
                    w_stash_load = 1'b1;
                end
            end
            SEL_S2: begin
                w_valid   = fetch_valid_i;
                w_consume = 1'b1;
                if (!w_lo_uncomp) begin
                    w_instr      = {16'b0, fetch_rdata_i[15:0]};
                    w_stash_load = 1'b1;
                end
            end
            SEL_S3: begin
                w_valid = 1'b1;
                w_instr = {16'b0, r_stash};
                w_addr  = r_stash_addr;
                w_err   = r_stash_err;
            end
            default: begin
                w_valid      = fetch_valid_i;
                w_consume    = 1'b1;
                w_stash_load = 1'b1;
                w_instr      = {fetch_rdata_i[15:0], r_stash};
                w_addr       = r_stash_addr;
                w_err        = r_stash_err | fetch_err_i;
                w_err_plus2  = fetch_err_i & ~r_stash_err;
            end
        endcase
    end

    assign w_active      = ~branch_i & ~rst_i;
    assign out_valid_o   = w_valid & w_active;
    assign w_accept      = out_valid_o & out_ready_i;
    assign fetch_ready_o = w_active & ((w_consume & w_accept) | w_fr_force);
    assign w_stash_we    = fetch_ready_o & w_stash_load;

    assign out_instr_o         = w_instr;
    assign out_addr_o          = w_addr;
    assign out_err_o           = w_err;
    assign out_err_plus2_o     = w_err_plus2;
    assign out_is_compressed_o = (w_instr[1:0] != INSTR_OPC_UNCOMP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stash_v   <= 1'b0;
            r_skip_low  <= 1'b0;
            r_stash_err <= 1'b0;
        end else if (branch_i) begin
            r_stash_v  <= 1'b0;
            r_skip_low <= branch_addr_i[1];
        end else begin
            if (w_stash_we) begin
                r_stash_v   <= 1'b1;
                r_stash_err <= fetch_err_i;
            end else if (w_accept && (w_sel == SEL_S3)) begin
                r_stash_v <= 1'b0;
            end
            if ((w_sel == SEL_S1) && fetch_ready_o) r_skip_low <= 1'b0;
        end
    end

    generate
        if (ResetAll) begin : g_data_rst
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_stash      <= 16'b0;
                    r_stash_addr <= 32'b0;
                end else if (w_stash_we) begin
                    r_stash      <= fetch_rdata_i[31:16];
                    r_stash_addr <= w_addr_p2;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk_i) begin
                if (w_stash_we) begin
                    r_stash      <= fetch_rdata_i[31:16];
                    r_stash_addr <= w_addr_p2;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ibex_instr_realigner.sv
// Directed cycle-by-cycle vectors plus hand-written reset/branch flush sequences.
module tb_ibex_instr_realigner;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_err_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_addr_o;
    logic        out_is_compressed_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    int total = 0;
    int bad   = 0;

    ibex_instr_realigner dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .branch_i           (branch_i),
        .branch_addr_i      (branch_addr_i),
        .fetch_valid_i      (fetch_valid_i),
        .fetch_ready_o      (fetch_ready_o),
        .fetch_rdata_i      (fetch_rdata_i),
        .fetch_addr_i       (fetch_addr_i),
        .fetch_err_i        (fetch_err_i),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .out_instr_o        (out_instr_o),
        .out_addr_o         (out_addr_o),
        .out_is_compressed_o(out_is_compressed_o),
        .out_err_o          (out_err_o),
        .out_err_plus2_o    (out_err_plus2_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        br;
        logic [31:0] br_addr;
        logic        fv;
        logic [31:0] w;
        logic [31:0] a;
        logic        fe;
        logic        rdy;
        logic        e_valid;
        logic        e_fr;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic        e_err;
        logic        e_p2;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic br, input logic [31:0] br_addr, input logic fv,
                       input logic [31:0] w, input logic [31:0] a, input logic fe,
                       input logic rdy, input logic e_valid, input logic e_fr,
                       input logic [31:0] e_instr, input logic [31:0] e_addr,
                       input logic e_err, input logic e_p2);
        vec_t v;
        v.br = br; v.br_addr = br_addr; v.fv = fv; v.w = w; v.a = a; v.fe = fe;
        v.rdy = rdy; v.e_valid = e_valid; v.e_fr = e_fr; v.e_instr = e_instr;
        v.e_addr = e_addr; v.e_err = e_err; v.e_p2 = e_p2;
        tbl.push_back(v);
    endtask

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic br, input logic [31:0] br_addr, input logic fv,
                         input logic [31:0] w, input logic [31:0] a, input logic fe,
                         input logic rdy);
        branch_i = br; branch_addr_i = br_addr; fetch_valid_i = fv;
        fetch_rdata_i = w; fetch_addr_i = a; fetch_err_i = fe; out_ready_i = rdy;
    endtask

    task automatic run_row(input int idx);
        vec_t v;
        string tag;
        v = tbl[idx];
        drive(v.br, v.br_addr, v.fv, v.w, v.a, v.fe, v.rdy);
        @(negedge clk_i);
        tag = $sformatf("row%0d", idx);
        check1({tag, " valid"}, {31'b0, out_valid_o}, {31'b0, v.e_valid});
        check1({tag, " fetch_ready"}, {31'b0, fetch_ready_o}, {31'b0, v.e_fr});
        if (v.e_valid) begin
            check1({tag, " instr"}, out_instr_o, v.e_instr);
            check1({tag, " addr"}, out_addr_o, v.e_addr);
            check1({tag, " err"}, {31'b0, out_err_o}, {31'b0, v.e_err});
            check1({tag, " err_plus2"}, {31'b0, out_err_plus2_o}, {31'b0, v.e_p2});
            check1({tag, " compressed"}, {31'b0, out_is_compressed_o},
                   {31'b0, (v.e_instr[1:0] != 2'b11)});
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //   br  br_addr       fv  w             a             fe  rdy  valid fr  instr         addr          err p2
        add(0, 32'h0,        1, 32'h00A00093, 32'h100,      0, 1,   1,    1,  32'h00A00093, 32'h100,      0,  0);
        add(0, 32'h0,        1, 32'h45014081, 32'h200,      0, 1,   1,    1,  32'h00004081, 32'h200,      0,  0);
        add(0, 32'h0,        0, 32'h0,        32'h0,        0, 1,   1,    0,  32'h00004501, 32'h202,      0,  0);
        add(0, 32'h0,        1, 32'h00934081, 32'h300,      0, 0,   1,    0,  32'h00004081, 32'h300,      0,  0);
        add(0, 32'h0,        1, 32'h00934081, 32'h300,      0, 1,   1,    1,  32'h00004081, 32'h300,      0,  0);
        add(0, 32'h0,        0, 32'h0,        32'h0,        0, 1,   0,    0,  32'h0,        32'h0,        0,  0);
        add(0, 32'h0,        1, 32'h123400A0, 32'h304,      0, 0,   1,    0,  32'h00A00093, 32'h302,      0,  0);
        add(0, 32'h0,        1, 32'h123400A0, 32'h304,      0, 1,   1,    1,  32'h00A00093, 32'h302,      0,  0);
        add(0, 32'h0,        0, 32'h0,        32'h0,        0, 1,   1,    0,  32'h00001234, 32'h306,      0,  0);
        add(1, 32'h402,      1, 32'hDEADBEEF, 32'h310,      0, 1,   0,    0,  32'h0,        32'h0,        0,  0);
        add(0, 32'h0,        1, 32'h00930000, 32'h400,      0, 0,   0,    1,  32'h0,        32'h0,        0,  0);
        add(0, 32'h0,        1, 32'h567800A0, 32'h404,      0, 1,   1,    1,  32'h00A00093, 32'h402,      0,  0);
        add(0, 32'h0,        0, 32'h0,        32'h0,        0, 1,   1,    0,  32'h00005678, 32'h406,      0,  0);
        add(0, 32'h0,        1, 32'h00934081, 32'h500,      0, 1,   1,    1,  32'h00004081, 32'h500,      0,  0);
        add(0, 32'h0,        1, 32'h123400A0, 32'h504,      1, 1,   1,    1,  32'h00A00093, 32'h502,      1,  1);
        add(0, 32'h0,        0, 32'h0,        32'h0,        0, 1,   1,    0,  32'h00001234, 32'h506,      1,  0);
        add(0, 32'h0,        1, 32'h45014081, 32'h600,      1, 1,   1,    1,  32'h00004081, 32'h600,      1,  0);
        add(0, 32'h0,        0, 32'h0,        32'h0,        0, 1,   1,    0,  32'h00004501, 32'h602,      1,  0);
        add(1, 32'h702,      1, 32'h0,        32'h0,        0, 1,   0,    0,  32'h0,        32'h0,        0,  0);
        add(0, 32'h0,        1, 32'h45014081, 32'h700,      0, 1,   1,    1,  32'h00004501, 32'h702,      0,  0);
        add(1, 32'hFFFFFFFE, 1, 32'h0,        32'h0,        0, 1,   0,    0,  32'h0,        32'h0,        0,  0);
        add(0, 32'h0,        1, 32'h00930001, 32'hFFFFFFFC, 0, 0,   0,    1,  32'h0,        32'h0,        0,  0);
        add(0, 32'h0,        1, 32'h567800A0, 32'h0,        0, 1,   1,    1,  32'h00A00093, 32'hFFFFFFFE, 0,  0);
        add(0, 32'h0,        0, 32'h0,        32'h0,        0, 1,   1,    0,  32'h00005678, 32'h2,        0,  0);

        rst_i = 1'b1;
        drive(0, 32'h0, 1, 32'h00A00093, 32'h100, 0, 1);
        #12;
        check1("reset valid", {31'b0, out_valid_o}, 32'h0);
        check1("reset fetch_ready", {31'b0, fetch_ready_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        foreach (tbl[i]) run_row(i);

        // Stash a compressed halfword, then hit it with an async reset mid-cycle.
        drive(0, 32'h0, 1, 32'h45014081, 32'h800, 0, 1);
        @(posedge clk_i);
        #1;
        drive(0, 32'h0, 0, 32'h0, 32'h0, 0, 1);
        #2;
        check1("pre-reset stash valid", {31'b0, out_valid_o}, 32'h1);
        rst_i = 1'b1;
        #1;
        check1("async reset valid", {31'b0, out_valid_o}, 32'h0);
        check1("async reset fetch_ready", {31'b0, fetch_ready_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check1("post-reset stash gone", {31'b0, out_valid_o}, 32'h0);
        @(posedge clk_i);
        #1;

        // Same again, flushed by a branch instead of reset.
        drive(0, 32'h0, 1, 32'h45014081, 32'h880, 0, 1);
        @(posedge clk_i);
        #1;
        drive(1, 32'h900, 0, 32'h0, 32'h0, 0, 1);
        @(negedge clk_i);
        check1("branch valid", {31'b0, out_valid_o}, 32'h0);
        check1("branch fetch_ready", {31'b0, fetch_ready_o}, 32'h0);
        @(posedge clk_i);
        #1;
        drive(0, 32'h0, 0, 32'h0, 32'h0, 0, 1);
        @(negedge clk_i);
        check1("post-branch stash gone", {31'b0, out_valid_o}, 32'h0);
        @(posedge clk_i);
        #1;
        drive(0, 32'h0, 1, 32'h00A00093, 32'h900, 0, 1);
        @(negedge clk_i);
        check1("post-branch valid", {31'b0, out_valid_o}, 32'h1);
        check1("post-branch instr", out_instr_o, 32'h00A00093);
        check1("post-branch addr", out_addr_o, 32'h900);
        @(posedge clk_i);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
